// File: rtl/net_buf_pkg.sv
// rtl/net_buf_pkg.sv - shared types and constants for the TX frame buffer
// Purpose: beat record layout, default frame limit and write-FSM states.
// Ports: none (package).
package net_buf_pkg;

  localparam int NET_DATA_WIDTH         = 64;
  localparam int MAX_ETH_FRAME_WORDS_64 = 200;

  typedef struct packed {
    logic [NET_DATA_WIDTH-1:0]   data;
    logic [NET_DATA_WIDTH/8-1:0] keep;
    logic                        last;
  } net_beat_t;

  typedef enum logic {
    WR_ACCEPT,
    WR_DROP
  } wr_state_t;

endpackage

// File: rtl/simple_dp_ram.sv
// rtl/simple_dp_ram.sv - one-write one-read RAM with registered read
// Purpose: beat storage for the frame buffer; read data appears the cycle after re.
// Ports:
//   clk            clock
//   we/waddr/wdata write port
//   re/raddr       read request
//   rdata          read data, registered
module simple_dp_ram #(
  parameter int WIDTH = 73,
  parameter int DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/net_tx_frame_buffer.sv
// rtl/net_tx_frame_buffer.sv - store-and-forward TX frame buffer with oversize drop
// Purpose: releases a frame to the MAC only after its last beat is stored; frames
//   longer than MAX_FRAME_WORDS are discarded whole and counted.
// Ports:
//   clk156, reset    clock, synchronous active-high reset
//   s_axis_*         input frame stream (tdata/tkeep/tlast/tvalid/tready)
//   m_axis_*         output frame stream to the MAC
//   frame_count      committed frames not yet fully sent
//   drop_count       oversize frames discarded (wraps)
module net_tx_frame_buffer
  import net_buf_pkg::*;
#(
  parameter int DATA_WIDTH      = NET_DATA_WIDTH,
  parameter int DEPTH           = 512,
  parameter int MAX_FRAME_WORDS = MAX_ETH_FRAME_WORDS_64,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                    clk156,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [$clog2(DEPTH):0]  frame_count,
  output logic [CNT_WIDTH-1:0]    drop_count
);

  localparam int KW     = DATA_WIDTH / 8;
  localparam int AW     = $clog2(DEPTH);
  localparam int PW     = AW + 1;
  localparam int BW     = $clog2(MAX_FRAME_WORDS + 2);
  localparam int BEAT_W = DATA_WIDTH + KW + 1;

  // rd_ptr advances on m_axis pops, so beats sitting in the skid stage still
  // count as used; fetch_ptr is the RAM read address and runs ahead of it.
  logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr, fetch_ptr, used;
  logic          full, ready_en;
  logic [BW-1:0] beat_cnt;
  wr_state_t     state, state_next;
  logic          do_write, do_commit, do_rollback, do_drop;

  assign used = wr_ptr - rd_ptr;
  assign full = (used == PW'(DEPTH));

  // Beat MAX_FRAME_WORDS+1 is the first one that makes the frame illegal.
  logic overflow_beat;
  assign overflow_beat = (beat_cnt >= BW'(MAX_FRAME_WORDS));

  always_ff @(posedge clk156) begin
    if (reset) state <= WR_ACCEPT;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    s_axis_tready = 1'b0;
    do_write      = 1'b0;
    do_commit     = 1'b0;
    do_rollback   = 1'b0;
    do_drop       = 1'b0;
    case (state)
      WR_ACCEPT: begin
        s_axis_tready = ready_en & ~full;
        if (s_axis_tvalid && s_axis_tready) begin
          if (overflow_beat) begin
            do_rollback = 1'b1;
            if (s_axis_tlast) do_drop = 1'b1;
            else              state_next = WR_DROP;
          end else begin
            do_write  = 1'b1;
            do_commit = s_axis_tlast;
          end
        end
      end
      WR_DROP: begin
        s_axis_tready = ready_en;
        if (s_axis_tvalid && s_axis_tready && s_axis_tlast) begin
          do_drop    = 1'b1;
          state_next = WR_ACCEPT;
        end
      end
      default: state_next = WR_ACCEPT;
    endcase
  end

  // ready_en holds s_axis_tready low until the first edge after reset is released.
  always_ff @(posedge clk156) begin
    if (reset) begin
      ready_en   <= 1'b0;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      beat_cnt   <= '0;
      drop_count <= '0;
    end else begin
      ready_en <= 1'b1;
      if (do_rollback) begin
        wr_ptr   <= commit_ptr;
        beat_cnt <= '0;
      end else if (do_write) begin
        wr_ptr <= wr_ptr + PW'(1);
        if (do_commit) begin
          commit_ptr <= wr_ptr + PW'(1);
          beat_cnt   <= '0;
        end else begin
          beat_cnt <= beat_cnt + BW'(1);
        end
      end
      if (do_drop) drop_count <= drop_count + CNT_WIDTH'(1);
    end
  end

  logic              fetch, rd_vld, pop;
  logic [1:0]        skid_cnt;
  logic [2:0]        occ_after;
  logic [BEAT_W-1:0] ram_rdata, skid_q0, skid_q1;

  simple_dp_ram #(
    .WIDTH(BEAT_W),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk  (clk156),
    .we   (do_write),
    .waddr(wr_ptr[AW-1:0]),
    .wdata({s_axis_tdata, s_axis_tkeep, s_axis_tlast}),
    .re   (fetch),
    .raddr(fetch_ptr[AW-1:0]),
    .rdata(ram_rdata)
  );

  assign m_axis_tvalid = (skid_cnt != 2'd0);
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast} = skid_q0;
  assign pop = m_axis_tvalid & m_axis_tready;

  // Only fetch when the beat in flight plus the skid entries, after this
  // cycle's pop, leave room: the skid can then never overflow, yet a steady
  // pop every cycle keeps one fetch per cycle going.
  assign occ_after = {1'b0, skid_cnt} + {2'b0, rd_vld} - {2'b0, pop};
  assign fetch     = (fetch_ptr != commit_ptr) && (occ_after < 3'd2);

  always_ff @(posedge clk156) begin
    if (reset) begin
      fetch_ptr   <= '0;
      rd_ptr      <= '0;
      rd_vld      <= 1'b0;
      skid_cnt    <= 2'd0;
      skid_q0     <= '0;
      skid_q1     <= '0;
      frame_count <= '0;
    end else begin
      rd_vld <= fetch;
      if (fetch) fetch_ptr <= fetch_ptr + PW'(1);
      if (pop)   rd_ptr    <= rd_ptr + PW'(1);
      case ({rd_vld, pop})
        2'b10: begin
          if (skid_cnt == 2'd0) skid_q0 <= ram_rdata;
          else                  skid_q1 <= ram_rdata;
          skid_cnt <= skid_cnt + 2'd1;
        end
        2'b01: begin
          skid_q0  <= skid_q1;
          skid_cnt <= skid_cnt - 2'd1;
        end
        2'b11: begin
          if (skid_cnt == 2'd1) begin
            skid_q0 <= ram_rdata;
          end else begin
            skid_q0 <= skid_q1;
            skid_q1 <= ram_rdata;
          end
        end
        default: ;
      endcase
      case ({do_commit, pop & m_axis_tlast})
        2'b10:   frame_count <= frame_count + PW'(1);
        2'b01:   frame_count <= frame_count - PW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_net_tx_frame_buffer.sv
// tb/tb_net_tx_frame_buffer.sv - self-checking bench for net_tx_frame_buffer
module tb_net_tx_frame_buffer;
  import net_buf_pkg::*;

  localparam int DW   = 64;
  localparam int KW   = 8;
  localparam int DEP  = 512;
  localparam int MAXW = 200;

  logic          clk156 = 1'b0;
  logic          reset;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic          s_axis_tlast, s_axis_tvalid, s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tlast, m_axis_tvalid, m_axis_tready;
  logic [9:0]    frame_count;
  logic [15:0]   drop_count;

  net_tx_frame_buffer #(
    .DATA_WIDTH(DW), .DEPTH(DEP), .MAX_FRAME_WORDS(MAXW), .CNT_WIDTH(16)
  ) dut (
    .clk156(clk156), .reset(reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .frame_count(frame_count), .drop_count(drop_count)
  );

  always #5 clk156 = ~clk156;

  int        n_checks = 0;
  int        n_errors = 0;
  net_beat_t exp_q[$];
  int        exp_drops = 0;
  int        stall_cycles = 0;
  int        acc_beats = 0;
  bit        in_frame = 0;
  bit        rand_ready = 0;
  bit        coin_en = 0, coin_pending = 0, coin_seen = 0;
  logic [9:0] coin_fc;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk156) begin
    #1;
    if (rand_ready) m_axis_tready = ($urandom_range(0, 1) == 1);
  end

  // Output monitor: scoreboard compare, intra-frame gap check, same-edge commit/pop check.
  always @(negedge clk156) begin
    if (reset) begin
      in_frame     = 0;
      coin_pending = 0;
    end else begin
      net_beat_t e;
      if (coin_pending) begin
        check("fc_same_edge", frame_count, coin_fc);
        coin_pending = 0;
      end
      if (coin_en && m_axis_tvalid && m_axis_tready && m_axis_tlast &&
          s_axis_tvalid && s_axis_tready && s_axis_tlast) begin
        coin_pending = 1;
        coin_seen    = 1;
        coin_fc      = frame_count;
      end
      if (in_frame) check("tvalid_gap", m_axis_tvalid, 1'b1);
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("m_beat", {m_axis_tdata, m_axis_tkeep, m_axis_tlast}, e);
        end
        in_frame = !m_axis_tlast;
      end
    end
  end

  task automatic send_beat(input net_beat_t b, input int gap_pct);
    bit hs;
    int waited;
    if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
      s_axis_tvalid = 1'b0;
      @(posedge clk156); #1;
    end
    s_axis_tdata  = b.data;
    s_axis_tkeep  = b.keep;
    s_axis_tlast  = b.last;
    s_axis_tvalid = 1'b1;
    hs = 0;
    waited = 0;
    while (!hs && waited < 5000) begin
      @(negedge clk156);
      hs = s_axis_tready;
      @(posedge clk156); #1;
      if (!hs) begin
        waited++;
        stall_cycles++;
      end
    end
    if (!hs) check("s_ready_timeout", 1'b0, 1'b1);
    else acc_beats++;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_frame(input int len, input bit idx_data, input int gap_pct);
    net_beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = idx_data ? 64'(i) : {$urandom(), $urandom()};
      b.last = (i == len - 1);
      b.keep = b.last ? (idx_data ? 8'h0F : 8'($urandom_range(1, 255))) : 8'hFF;
      if (len <= MAXW) exp_q.push_back(b);
      send_beat(b, gap_pct);
    end
    if (len > MAXW) exp_drops++;
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && g < 30000) begin
      @(posedge clk156); #1;
      g++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    net_beat_t b;
    int        g;
    bit        tx_done;
    reset = 1'b1;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    repeat (3) @(posedge clk156);
    #1;
    check("rst_m_tvalid", m_axis_tvalid, 1'b0);
    check("rst_m_tdata", m_axis_tdata, 64'd0);
    check("rst_s_tready", s_axis_tready, 1'b0);
    check("rst_frame_count", frame_count, 0);
    check("rst_drop_count", drop_count, 0);
    reset = 1'b0;
    check("s_ready_before_edge", s_axis_tready, 1'b0);
    @(posedge clk156); #1;
    check("s_ready_rise", s_axis_tready, 1'b1);

    // 8-beat frame, latency of two edges after the s-side tlast
    m_axis_tready = 1'b1;
    send_frame(8, 1, 0);
    check("lat_edge0", m_axis_tvalid, 1'b0);
    @(posedge clk156); #1;
    check("lat_edge1", m_axis_tvalid, 1'b0);
    @(posedge clk156); #1;
    check("lat_edge2", m_axis_tvalid, 1'b1);
    wait_drain();

    // 201-beat oversize frame then a 4-beat frame
    stall_cycles = 0;
    send_frame(201, 0, 0);
    send_frame(4, 0, 0);
    check("t2_no_stall", stall_cycles, 0);
    check("t2_drop_count", drop_count, exp_drops);
    wait_drain();

    // exactly MAX_FRAME_WORDS beats is kept
    send_frame(200, 0, 0);
    wait_drain();
    check("t3_drop_count", drop_count, exp_drops);
    check("t3_frame_count", frame_count, 0);

    // fill: 3x200 beats with the MAC stalled
    m_axis_tready = 1'b0;
    acc_beats = 0;
    tx_done = 0;
    fork
      begin
        send_frame(200, 0, 0);
        send_frame(200, 0, 0);
        send_frame(200, 0, 0);
        tx_done = 1;
      end
    join_none
    g = 0;
    while (acc_beats < 512 && g < 3000) begin @(posedge clk156); #1; g++; end
    repeat (4) @(posedge clk156);
    @(negedge clk156);
    check("t4_s_tready_full", s_axis_tready, 1'b0);
    check("t4_accepted", acc_beats, 512);
    check("t4_frame_count", frame_count, 2);
    @(posedge clk156); #1;
    m_axis_tready = 1'b1;
    g = 0;
    while (!tx_done && g < 5000) begin @(posedge clk156); #1; g++; end
    check("t4_tx_done", tx_done, 1'b1);
    wait_drain();
    check("t4_frame_count_end", frame_count, 0);

    // commit of B on the edge that pops A's last beat
    coin_en = 1;
    coin_seen = 0;
    send_frame(4, 0, 0);
    send_frame(6, 0, 0);
    wait_drain();
    coin_en = 0;
    check("t5_coincidence_seen", coin_seen, 1'b1);

    // reset mid-input and mid-output
    m_axis_tready = 1'b0;
    send_frame(10, 0, 0);
    for (int i = 0; i < 5; i++) begin
      b.data = {$urandom(), $urandom()};
      b.keep = 8'hFF;
      b.last = 1'b0;
      send_beat(b, 0);
    end
    repeat (3) @(posedge clk156);
    #1;
    m_axis_tready = 1'b1;
    @(posedge clk156); #1;
    m_axis_tready = 1'b0;
    reset = 1'b1;
    s_axis_tvalid = 1'b0;
    @(posedge clk156); #1;
    check("t6_m_tvalid", m_axis_tvalid, 1'b0);
    check("t6_frame_count", frame_count, 0);
    check("t6_drop_count", drop_count, 0);
    check("t6_s_tready", s_axis_tready, 1'b0);
    exp_q.delete();
    exp_drops = 0;
    @(posedge clk156); #1;
    reset = 1'b0;
    @(posedge clk156); #1;

    // random traffic with random MAC backpressure
    rand_ready = 1;
    for (int f = 0; f < 1000; f++) begin
      int r, len;
      r = $urandom_range(0, 99);
      if (r < 5)       len = $urandom_range(201, 210);
      else if (r < 15) len = $urandom_range(17, 200);
      else             len = $urandom_range(1, 16);
      send_frame(len, 0, 20);
    end
    rand_ready = 0;
    #2;
    m_axis_tready = 1'b1;
    wait_drain();
    check("t6_final_drop_count", drop_count, exp_drops);
    check("t6_final_frame_count", frame_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
